digest_stream_out: RTL

- Read side of the hash state register bank: takes a snapshot of the final H[0:7] words when the hash core signals completion.
- Streams the digest out as 32-bit beats over a valid/ready stream, truncated per SHA variant.
- Sits between the hash update stage and the host/DMA output interface, so the core can start the next message while the digest drains.

---
 rtl/digest_stream_out.sv | 89 ++++++++
 1 files changed

// File: rtl/digest_stream_out.sv
// Snapshot of the final hash state words, streamed out as 32-bit beats over valid/ready.
// The core may start its next message while the held digest drains.
module digest_stream_out #(
  parameter bit SWAP_BYTES = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       sha_type,
  input  logic             capture,
  input  logic [0:7][63:0] H,
  output logic             idle,
  output logic [31:0]      m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic             overrun
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]       state;
  logic [0:7][63:0] snap;
  logic [1:0]       type_q;
  logic [3:0]       cnt;
  logic [3:0]       last_idx;
  logic [63:0]      word;
  logic [31:0]      beat;

  always_comb begin
    last_idx = 4'd15;
    case (type_q)
      2'b00:   last_idx = 4'd6;
      2'b01:   last_idx = 4'd7;
      2'b10:   last_idx = 4'd11;
      default: last_idx = 4'd15;
    endcase
  end

  // 64-bit words emit their high half on even beats, low half on odd beats
  assign word = type_q[1] ? snap[cnt[3:1]] : snap[cnt[2:0]];
  assign beat = (type_q[1] && cnt[0]) ? word[31:0] : word[63:32];

  generate
    if (SWAP_BYTES) begin : g_swap
      assign m_tdata = {beat[7:0], beat[15:8], beat[23:16], beat[31:24]};
    end else begin : g_noswap
      assign m_tdata = beat;
    end
  endgenerate

  // All outputs decode from registers only, so m_tready never reaches m_tvalid
  assign m_tvalid = (state == SEND);
  assign m_tlast  = m_tvalid && (cnt == last_idx);
  assign idle     = (state == IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      snap    <= '0;
      type_q  <= 2'b00;
      cnt     <= 4'd0;
      overrun <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (capture) begin
            snap   <= H;
            type_q <= sha_type;
            cnt    <= 4'd0;
            state  <= SEND;
          end
        end
        default: begin
          if (capture) overrun <= 1'b1;
          if (m_tready) begin
            if (cnt == last_idx) begin
              cnt   <= 4'd0;
              state <= IDLE;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
      endcase
    end
  end

endmodule
